// File: rtl/div_seq_32_if.sv
// Start/ready handshake and operand/result bus between the multdiv stall logic and div_seq_32.
interface div_seq_32_if;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/div_seq_32.sv
// Sequential 32-bit signed restoring divider: one quotient bit per cycle, quotient truncated toward zero.
// Divide-by-zero and MIN/-1 overflow complete in one cycle with the exception flag set.
module div_seq_32 (
  input logic         clock,
  input logic         reset,
  div_seq_32_if.slave bus
);

  localparam int unsigned W    = 32;
  localparam int unsigned RW   = W + 1;
  localparam int unsigned CW   = 5;
  localparam logic [CW-1:0] LAST    = CW'(W - 1);
  localparam logic [W-1:0]  MIN_INT = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [RW-1:0] rem;
  logic [W-1:0]  quo;
  logic [W-1:0]  babs;
  logic          sign;
  logic          exc_pend;
  logic [CW-1:0] cnt;

  logic [W-1:0]  result_q;
  logic          exception_q;
  logic          rdy_q;

  logic [W-1:0]  a_abs_c;
  logic [W-1:0]  b_abs_c;
  logic          div_zero_c;
  logic          ovf_c;
  logic [RW-1:0] rem_sh_c;
  logic [RW-1:0] trial_c;

  // Operand magnitudes; |0x80000000| stays 0x80000000 as an unsigned value.
  always_comb begin
    a_abs_c    = bus.data_operandA;
    b_abs_c    = bus.data_operandB;
    if (bus.data_operandA[W-1]) a_abs_c = (~bus.data_operandA) + W'(1);
    if (bus.data_operandB[W-1]) b_abs_c = (~bus.data_operandB) + W'(1);
    div_zero_c = (bus.data_operandB == '0);
    ovf_c      = (bus.data_operandA == MIN_INT) && (bus.data_operandB == '1);
  end

  // One restoring step: shift {rem, quo} left, then trial-subtract the divisor magnitude.
  always_comb begin
    rem_sh_c = {rem[RW-2:0], quo[W-1]};
    trial_c  = rem_sh_c - {1'b0, babs};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rem         <= '0;
      quo         <= '0;
      babs        <= '0;
      sign        <= 1'b0;
      exc_pend    <= 1'b0;
      cnt         <= '0;
      result_q    <= '0;
      exception_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (bus.ctrl_DIV) begin
        // A start in any state aborts whatever is in flight.
        cnt  <= '0;
        rem  <= '0;
        babs <= b_abs_c;
        if (div_zero_c) begin
          quo      <= '0;
          sign     <= 1'b0;
          exc_pend <= 1'b1;
          state    <= DONE;
        end else if (ovf_c) begin
          quo      <= MIN_INT;
          sign     <= 1'b0;
          exc_pend <= 1'b1;
          state    <= DONE;
        end else begin
          quo      <= a_abs_c;
          sign     <= bus.data_operandA[W-1] ^ bus.data_operandB[W-1];
          exc_pend <= 1'b0;
          state    <= RUN;
        end
      end else begin
        case (state)
          RUN: begin
            if (!trial_c[RW-1]) begin
              rem <= trial_c;
              quo <= {quo[W-2:0], 1'b1};
            end else begin
              rem <= rem_sh_c;
              quo <= {quo[W-2:0], 1'b0};
            end
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= DONE;
          end
          DONE: begin
            result_q    <= sign ? ((~quo) + W'(1)) : quo;
            exception_q <= exc_pend;
            rdy_q       <= 1'b1;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exception_q;
  assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_div_seq_32.sv
// Directed and randomized checks of div_seq_32: values, exception flag and RDY timing.
module tb_div_seq_32;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  div_seq_32_if bus ();

  div_seq_32 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drive a start in the current cycle; it is sampled at the next rising edge (E0).
  task automatic go_now(input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    #1;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic go(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    go_now(a, b);
  endtask

  // Number of edges after E0 until RDY is seen, or -1 if it never comes.
  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic expect_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic exp_e, input int exp_lat);
    int lat;
    go(a, b);
    wait_rdy(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_q"}, bus.data_result, exp_q);
    check({tag, "_exc"}, 32'(bus.data_exception), 32'(exp_e));
    @(posedge clock);
    #1;
    check({tag, "_rdy_drop"}, 32'(bus.data_resultRDY), 32'(0));
  endtask

  // Reference: truncating signed division with the two exception cases.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic e);
    int sa, sb;
    sa = a;
    sb = b;
    if (sb == 0) begin
      q = 32'h0;
      e = 1'b1;
    end else if (sa == 32'sh8000_0000 && sb == -1) begin
      q = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = 32'(sa / sb);
      e = 1'b0;
    end
  endtask

  task automatic gen(output logic [31:0] a, output logic [31:0] b);
    int unsigned mode;
    mode = $urandom_range(0, 7);
    a = $urandom;
    b = $urandom;
    case (mode)
      0: b = 32'h0;
      1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      2: begin
        b = 32'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) b = (~b) + 32'd1;
      end
      3: a = 32'h8000_0000;
      default: ;
    endcase
  endtask

  initial begin
    logic        seen;
    int          lat;
    int          pulses;
    logic [31:0] a, b, na, nb, q;
    logic        e;

    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 32'h0;
    bus.data_operandB = 32'h0;
    reset             = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_result", bus.data_result, 32'h0);
    check("rst_exc", 32'(bus.data_exception), 32'(0));
    check("rst_rdy", 32'(bus.data_resultRDY), 32'(0));
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      seen = seen | bus.data_resultRDY | bus.data_exception | (|bus.data_result);
    end
    check("idle_quiet", 32'(seen), 32'(0));

    expect_op("p100_p7", 32'd100, 32'd7, 32'd14, 1'b0, 33);
    expect_op("n100_p7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 33);
    expect_op("p100_n7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 33);
    expect_op("n100_n7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0, 33);
    expect_op("p7_p100", 32'd7, 32'd100, 32'd0, 1'b0, 33);
    expect_op("min_2", 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, 33);
    expect_op("max_1", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b0, 33);
    expect_op("min_min", 32'h8000_0000, 32'h8000_0000, 32'd1, 1'b0, 33);
    expect_op("div0", 32'd55, 32'd0, 32'd0, 1'b1, 1);
    expect_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1);
    expect_op("after_exc", 32'd9, 32'd3, 32'd3, 1'b0, 33);

    // Restart at E10 with new operands; only the second division completes.
    go(32'd1000, 32'd10);
    pulses = 0;
    repeat (9) begin
      @(posedge clock);
      #1;
      pulses += int'(bus.data_resultRDY);
    end
    go(32'd81, 32'd9);
    wait_rdy(lat);
    check("abort_no_rdy", 32'(pulses), 32'(0));
    check("abort_lat", 32'(lat), 32'(33));
    check("abort_q", bus.data_result, 32'd9);

    // Leave nonzero outputs behind, then reset in the middle of a division.
    expect_op("pre_rst", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1);
    go(32'd100, 32'd7);
    repeat (19) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midrst_result", bus.data_result, 32'h0);
    check("midrst_exc", 32'(bus.data_exception), 32'(0));
    check("midrst_rdy", 32'(bus.data_resultRDY), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      seen = seen | bus.data_resultRDY;
    end
    check("midrst_no_rdy", 32'(seen), 32'(0));

    // Random pairs, each next start issued in the RDY cycle of the previous one.
    gen(a, b);
    go(a, b);
    for (int i = 0; i < 150; i++) begin
      ref_div(a, b, q, e);
      wait_rdy(lat);
      check("rnd_lat", 32'(lat), e ? 32'd1 : 32'd33);
      check("rnd_q", bus.data_result, q);
      check("rnd_exc", 32'(bus.data_exception), 32'(e));
      if (i < 149) begin
        gen(na, nb);
        go_now(na, nb);
        check("rnd_rdy_drop", 32'(bus.data_resultRDY), 32'(0));
        a = na;
        b = nb;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
